// File: rtl/ring_cnt_pkg.sv
// Shared constants and seed helper for the ring/Johnson counter family.
// Purely declarative; no latency or backpressure.
package ring_cnt_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;

  // Start-of-sequence code: LSB set for ring, all zeros for Johnson.
  function automatic logic [31:0] seed(input logic mode, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (mode == MODE_JOHNSON) ? 32'd0 : (32'd1 & mask);
  endfunction

endpackage

// File: rtl/ring_code_check.sv
// Combinational legality check of a ring (one-hot) or Johnson code.
// Zero latency; no flow control.
module ring_code_check
  import ring_cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] code,
  input  logic             mode,
  output logic             valid
);

  logic [WIDTH-2:0] edges;

  // A Johnson code has at most one boundary between its run of ones and zeros.
  assign edges = code[WIDTH-1:1] ^ code[WIDTH-2:0];
  assign valid = (mode == MODE_JOHNSON) ? $onehot0(edges) : $onehot(code);

endmodule

// File: rtl/ring_johnson_counter.sv
// WIDTH-bit ring / Johnson phase counter with direction, load and terminal-count pulse.
// One-cycle registered latency on all outputs; no backpressure, steps whenever en is high.
// Optional RING_JOHNSON_SELF_CORRECT_EN rejects illegal loads and reseeds illegal states.
module ring_johnson_counter
  import ring_cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tc,
  output logic             err
);

  logic             mode_q;
  logic [WIDTH-1:0] cnt_q;
  logic             tc_q;
  logic             err_q;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] seed_q;
  logic             fix_req;
  logic             load_ok;

  assign seed_in = WIDTH'(seed(mode, WIDTH));
  assign seed_q  = WIDTH'(seed(mode_q, WIDTH));

  always_comb begin
    step_val = cnt_q;
    if (dir == DIR_LEFT) begin
      if (mode_q == MODE_JOHNSON) step_val = {cnt_q[WIDTH-2:0], ~cnt_q[WIDTH-1]};
      else                        step_val = {cnt_q[WIDTH-2:0],  cnt_q[WIDTH-1]};
    end else begin
      if (mode_q == MODE_JOHNSON) step_val = {~cnt_q[0], cnt_q[WIDTH-1:1]};
      else                        step_val = { cnt_q[0], cnt_q[WIDTH-1:1]};
    end
  end

`ifdef RING_JOHNSON_SELF_CORRECT_EN
  logic cnt_valid;
  logic load_valid;

  ring_code_check #(.WIDTH(WIDTH)) u_chk_load (
    .code  (load_val),
    .mode  (mode_q),
    .valid (load_valid)
  );

  ring_code_check #(.WIDTH(WIDTH)) u_chk_cnt (
    .code  (cnt_q),
    .mode  (mode_q),
    .valid (cnt_valid)
  );

  assign fix_req = ~cnt_valid;
  assign load_ok = load_valid;
`else
  assign fix_req = 1'b0;
  assign load_ok = 1'b1;
`endif

  // Priority: reset > mode reseed > self-correct > load > step > hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= seed_in;
      mode_q <= mode;
      tc_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      tc_q  <= 1'b0;
      err_q <= 1'b0;
      if (mode != mode_q) begin
        cnt_q  <= seed_in;
        mode_q <= mode;
      end else if (fix_req) begin
        cnt_q <= seed_q;
        err_q <= 1'b1;
      end else if (load) begin
        if (load_ok) cnt_q <= load_val;
        else         err_q <= 1'b1;
      end else if (en) begin
        cnt_q <= step_val;
        tc_q  <= (step_val == seed_q);
      end
    end
  end

  assign cnt_out = cnt_q;
  assign tc      = tc_q;
  assign err     = err_q;

endmodule

// File: doc/ring_johnson_counter.md
Name: ring_johnson_counter

Overview:
Parametrised successor to the team's fixed 4-bit ring counter. It provides a WIDTH-bit one-hot ring counter or Johnson (twisted-ring) counter, selectable at run time. It supports shift direction, enable, parallel load and a terminal-count pulse. It is used as a phase/strobe generator for sequenced lab datapaths.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..32.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset (reset==0 at posedge clk resets the block).
en  input  1  advance one step per cycle when high.
mode  input  1  0 = ring (one-hot), 1 = Johnson.
dir  input  1  0 = shift toward MSB (left), 1 = shift toward LSB (right).
load  input  1  parallel load strobe.
load_val  input  WIDTH  value captured when load is accepted.
cnt_out  output  WIDTH  registered counter state.
tc  output  1  registered terminal-count pulse.
err  output  1  registered illegal-code pulse; constant 0 unless the optional feature is compiled in.

Behaviour:
- Seed values: ring seed = 1 (LSB set, all other bits 0); Johnson seed = all zeros.
- Reset values:
  - cnt_out = seed of the current mode input.
  - tc = 0, err = 0.
  - Internal mode_q = mode.
- Action priority per posedge, highest first: reset > reseed > load > step > hold.
- Reseed: if mode != mode_q, then cnt_out <= seed(mode) and mode_q <= mode. In that cycle, load and en are ignored and tc = 0.
- Ring step, left: cnt <= {cnt[W-2:0], cnt[W-1]}.
- Ring step, right: cnt <= {cnt[0], cnt[W-1:1]}.
- Johnson step, left: cnt <= {cnt[W-2:0], ~cnt[W-1]}.
- Johnson step, right: cnt <= {~cnt[0], cnt[W-1:1]}.
- Load: cnt_out <= load_val, visible one cycle after load is sampled high. load with en=1 performs the load only; no step that cycle.
- dir may change on any cycle. It takes effect on the next step, and no reseed occurs.
- tc:
  - tc <= 1 exactly when the action this cycle is a step and the next value equals seed(mode_q); otherwise tc <= 0.
  - tc is therefore high in the same cycle that cnt_out shows the seed after a step.
  - Period with continuous en from seed: WIDTH cycles in ring mode, 2*WIDTH cycles in Johnson mode, in either direction.
  - A load of the seed value does not raise tc.
- Valid codes:
  - Ring: exactly one bit set.
  - Johnson: at most one transition between adjacent bits i and i+1, for i = 0..WIDTH-2.
- Latency: one cycle from input sample to cnt_out, tc and err. No combinational path from inputs to outputs.

Optional Feature:
Macro RING_JOHNSON_SELF_CORRECT_EN.
- Defined:
  - A load whose load_val is invalid for mode_q is rejected: cnt_out holds and err pulses high for one cycle.
  - If cnt_out itself is ever invalid for mode_q (e.g. upset or forced value), the next posedge reseeds instead of stepping, loading or holding. err pulses for one cycle and tc = 0.
  - Priority for this self-correct reseed: below reset and mode reseed, above load.
- Undefined: loads are unconditional, no correction is applied, err is tied 0.

Decomposition:
- Package ring_cnt_pkg holds:
  - Constants MODE_RING=1'b0, MODE_JOHNSON=1'b1, DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
  - A seed(mode, WIDTH) function.
- One combinational sub-module, ring_code_check:
  - Inputs: WIDTH code, mode. Output: valid.
  - Instantiated twice: once for load_val, once for cnt_out.
  - Used only when RING_JOHNSON_SELF_CORRECT_EN is defined.

Test Plan:
1. WIDTH=4, mode=0, reset=0 for one cycle, then reset=1, en=1, dir=0 -> cnt_out 0001, 0010, 0100, 1000, 0001; tc=1 only with the final 0001.
2. mode=1, reset, en=1, dir=0 -> 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; tc=1 only on the final 0000. Repeat with dir=1 -> 1000, 1100, ..., 0000 after 8 steps.
3. Ring at 0100, en=1, mode switched to 1 -> next cnt_out=0000, tc=0; stepping resumes in Johnson form on the following cycle.
4. Ring mode, load=1, en=1, load_val=0110:
   - Feature on -> cnt_out unchanged, err=1 for one cycle.
   - Feature off -> cnt_out=0110, err=0.
   - load_val=0100 -> cnt_out=0100 in both builds.
5. Feature on, cnt_out forced to 0101 in ring mode with en=1 -> next cycle 0001, err=1, tc=0.
6. Mid-sequence, reset=0 together with load=1, en=1 and a mode change -> cnt_out equals seed(mode) and tc=err=0 on that edge.
